// File: rtl/path_step_sequencer_if.sv
// Avalon-MM slave bus bundle for the path step sequencer register file.
interface path_step_sequencer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/path_step_sequencer.sv
// Path step sequencer: CPU-filled waypoint FIFO replayed onto out_port, one
// waypoint per dwell interval or per external advance strobe, irq when dry.
module path_step_sequencer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  path_step_sequencer_if.slave avs,
  input  logic                 advance,
  output logic [31:0]          out_port,
  output logic                 path_valid,
  output logic                 irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             irq_q, irq_d;
  logic [31:0]      out_q, out_d;
  logic             pv_q, pv_d;
  logic [31:0]      fifo_mem [DEPTH];

  logic wr_en, push, ctrl_wr, dwell_wr;
  logic start, stop, flush, irq_clr;
  logic full, empty_eff, step, pop, push_ok, irq_set;

  // Decode bus writes; stop overrides start, flush makes the queue look empty now
  always_comb begin
    wr_en     = avs.chipselect & ~avs.write_n;
    push      = wr_en & (avs.address == 2'd0);
    ctrl_wr   = wr_en & (avs.address == 2'd2);
    dwell_wr  = wr_en & (avs.address == 2'd3);
    stop      = ctrl_wr & avs.writedata[1];
    start     = ctrl_wr & avs.writedata[0] & ~avs.writedata[1];
    flush     = ctrl_wr & avs.writedata[2];
    irq_clr   = ctrl_wr & avs.writedata[3];
    full      = (count_q == CW'(DEPTH));
    empty_eff = (count_q == '0) | flush;
    step      = (state_q == ST_RUN) & ~stop & ((cnt_q == '0) | advance);
    pop       = step & ~empty_eff;
    push_ok   = push & (~full | pop);
  end

  // Next-state logic for sequencer, counter, FIFO bookkeeping and registers
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dwell_d  = dwell_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    irq_d    = irq_q;
    out_d    = out_q;
    pv_d     = pv_q;
    irq_set  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (step) begin
          if (pop) begin
            out_d = fifo_mem[rd_ptr_q];
            pv_d  = 1'b1;
            cnt_d = dwell_q;
          end else begin
            state_d = ST_DONE;
            irq_set = 1'b1;
          end
        end else if (!stop) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (stop) begin
      state_d = ST_IDLE;
      pv_d    = 1'b0;
    end

    if (start | irq_clr) irq_d = 1'b0;
    if (irq_set)         irq_d = 1'b1;

    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop);
      if (push & ~push_ok) ovf_d = 1'b1;
    end

    if (dwell_wr) dwell_d = CNT_W'(avs.writedata);
  end

  // State and control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      dwell_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
      out_q    <= '0;
      pv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dwell_q  <= dwell_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
      out_q    <= out_d;
      pv_q     <= pv_d;
    end
  end

  // Waypoint storage; contents are don't-care while the occupancy is zero
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= avs.writedata;
  end

  // Zero-wait-state register read mux
  always_comb begin
    avs.readdata = '0;
    case (avs.address)
      2'd0: avs.readdata = out_q;
      2'd1: avs.readdata = {20'd0, ovf_q, irq_q, state_q, 8'(count_q)};
      2'd2: avs.readdata = '0;
      2'd3: avs.readdata = 32'(dwell_q);
      default: avs.readdata = '0;
    endcase
  end

  assign out_port   = out_q;
  assign path_valid = pv_q;
  assign irq        = irq_q;

endmodule
